stopwatch_ctl: RTL and testbench
================================

STOPWATCH_CTL -- requirements
Module: stopwatch_ctl

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, required stable time of a button in ms.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port btn_start_stop  input  1  raw, asynchronous, bouncing start/stop push-button.
REQ-006 Port btn_clear  input  1  raw, asynchronous, bouncing clear push-button.
REQ-007 Port init_regs  output  1  zeroes downstream seconds counter; high while in IDLE.
REQ-008 Port count_enabled  output  1  lets downstream counter advance; high while in RUNNING.
REQ-009 Port paused_led  output  1  status LED; high while in PAUSED.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 DEBOUNCE_CYCLES SHALL equal (CLK_FREQ/1000)*DEBOUNCE_MS; elaboration SHALL fail if the result is below 1.
REQ-012 Debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced value restarts the count from 0.
REQ-013 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); it SHALL saturate and never wrap.
REQ-014 Each debounced level SHALL produce a press pulse: high for exactly one cycle, on the cycle after the debounced level rises 0->1; release (1->0) SHALL produce no pulse.
REQ-015 FSM states: IDLE, RUNNING, PAUSED; state register updates on the clock edge at which a press pulse is high.
REQ-016 IDLE + start pulse -> RUNNING; RUNNING + start pulse -> PAUSED; PAUSED + start pulse -> RUNNING.
REQ-017 Clear pulse in any state -> IDLE.
REQ-018 Simultaneous clear and start pulses: clear wins, next state IDLE.
REQ-019 Outputs SHALL be Moore-decoded from the state register only, glitch-free, with no combinational path from a button input.
REQ-020 Output table: IDLE = (init_regs 1, count_enabled 0, paused_led 0); RUNNING = (0,1,0); PAUSED = (0,0,1).
REQ-021 Holding a button SHALL yield exactly one press pulse, independent of hold length.
REQ-022 Latency from a clean raw rising edge to the state/output change SHALL be exactly 2 + DEBOUNCE_CYCLES + 2 cycles, constant for every press.

Reset
REQ-023 reset SHALL force state to IDLE, all synchronizer flops, debounced levels and debounce counters to 0, and press pulses to 0.
REQ-024 While reset is high, outputs SHALL be (init_regs 1, count_enabled 0, paused_led 0).
REQ-025 A reset asserted mid-debounce SHALL discard the partial count; a button still held after reset release SHALL be debounced afresh and SHALL yield one pulse.

Structure
REQ-026 State encodings (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2) SHALL live in the shared package stopwatch_pkg; 2'd3 SHALL recover to IDLE.
REQ-027 Synchronizer, debounce counter and press pulse generator SHALL form one sub-module, btn_debounce, instantiated once per button.
REQ-028 stopwatch_ctl SHALL contain only the two btn_debounce instances, the FSM and the output decode.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4 -> DEBOUNCE_CYCLES=4)
REQ-029 Reset then idle -> init_regs=1, count_enabled=0, paused_led=0 on every cycle.
REQ-030 Clean start press held 20 cycles -> count_enabled rises exactly 8 cycles after the raw edge; only one pulse; state RUNNING.
REQ-031 Start press with bounces (1,0,1,1,0, then stable 1) -> exactly one transition, 8 cycles after the last raw edge; 3-cycle glitches produce nothing.
REQ-032 Press sequence start, start, start -> RUNNING, PAUSED (paused_led=1, count_enabled=0), RUNNING.
REQ-033 Start and clear pressed on the same cycle from PAUSED -> IDLE, init_regs=1.
REQ-034 reset pulsed while start is held 2 cycles into debounce -> IDLE; after reset release, one pulse 8 cycles later -> RUNNING.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_t          : FSM state encoding (IDLE=0, RUNNING=1, PAUSED=2; 3 is
//                      unused and recovers to IDLE).
//   debounce_cycles(): number of clock cycles that make up the debounce window.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    // (clk_freq / 1000) clock cycles per millisecond, times the window in ms.
    function automatic int debounce_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, press pulse.
//   clk    : clock, all state updates on posedge
//   reset  : synchronous, active-high; clears every flop in this block
//   btn    : raw, asynchronous, bouncing button input
//   press  : one-cycle pulse, the cycle after the debounced level rises
//
// The debounced level follows the synchronized input only after the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any cycle on which they
// agree again restarts the count from zero.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_window
            $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;

            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                // The >= guard also keeps the counter from ever wrapping.
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Rising edge of the debounced level only; releases are ignored.
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/stopwatch_ctl.sv
// Stopwatch control FSM driven by two bouncing push-buttons.
//   clk            : clock, all state updates on posedge
//   reset          : synchronous, active-high; forces IDLE
//   btn_start_stop : raw start/stop button
//   btn_clear      : raw clear button
//   init_regs      : high in IDLE (zeroes the downstream seconds counter)
//   count_enabled  : high in RUNNING (downstream counter advances)
//   paused_led     : high in PAUSED
//
// Start/stop toggles RUNNING <-> PAUSED (and leaves IDLE); clear returns to
// IDLE from anywhere and wins over a simultaneous start/stop press.
module stopwatch_ctl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ    = 100000000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_clear,
    output logic init_regs,
    output logic count_enabled,
    output logic paused_led
);

    localparam int DEBOUNCE_CYCLES = debounce_cycles(CLK_FREQ, DEBOUNCE_MS);

    logic   start_press;
    logic   clear_press;
    state_t state;
    state_t state_next;
    logic   init_next;
    logic   count_next;
    logic   paused_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start_stop),
        .press (start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clear_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear_press) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_press) state_next = RUNNING;
                RUNNING: if (start_press) state_next = PAUSED;
                PAUSED:  if (start_press) state_next = RUNNING;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode of the next state, captured in flops alongside the state
    // register. The outputs therefore always equal the decode of the state
    // register, change on the same edge as the state, and cannot glitch when
    // several state bits flip at once (e.g. RUNNING -> PAUSED).
    always_comb begin
        init_next   = 1'b0;
        count_next  = 1'b0;
        paused_next = 1'b0;
        case (state_next)
            RUNNING: count_next  = 1'b1;
            PAUSED:  paused_next = 1'b1;
            default: init_next   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_regs     <= 1'b1;
            count_enabled <= 1'b0;
            paused_led    <= 1'b0;
        end else begin
            init_regs     <= init_next;
            count_enabled <= count_next;
            paused_led    <= paused_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Testbench for stopwatch_ctl with CLK_FREQ=1000, DEBOUNCE_MS=4 (4-cycle
// debounce window, 8-cycle press-to-output latency).
// Stimulus pushes {cycle, outputs} expectations into exp_q; the monitor pops
// one entry whenever the output triple {init_regs, count_enabled, paused_led}
// changes and checks both the value and the cycle on which it appeared.
module tb_stopwatch_ctl;

    localparam int LAT = 8;
    localparam logic [2:0] O_IDLE    = 3'b100;
    localparam logic [2:0] O_RUNNING = 3'b010;
    localparam logic [2:0] O_PAUSED  = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_start_stop = 1'b0;
    logic btn_clear = 1'b0;
    logic init_regs;
    logic count_enabled;
    logic paused_led;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [2:0] prev_outs;
    logic [34:0] exp_q[$];

    stopwatch_ctl #(.CLK_FREQ(1000), .DEBOUNCE_MS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .init_regs      (init_regs),
        .count_enabled  (count_enabled),
        .paused_led     (paused_led)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [2:0]  cur;
        logic [34:0] e;
        cur = {init_regs, count_enabled, paused_led};
        if (mon_en && cur !== prev_outs) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: outs=%b at cycle %0d, no change expected", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e[2:0] || cyc != int'(e[34:3])) begin
                    n_bad++;
                    $display("FAIL transition: outs=%b at cycle %0d, expected outs=%b at cycle %0d",
                             cur, cyc, e[2:0], int'(e[34:3]));
                end
            end
        end
        prev_outs = cur;
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int at, input logic [2:0] o);
        exp_q.push_back({32'(at), o});
    endtask

    task automatic check_outs(input string name, input logic [2:0] want);
        logic [2:0] got;
        got = {init_regs, count_enabled, paused_led};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: outs=%b, expected %b (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Press the selected button(s) for `hold` cycles, then release and let the
    // release settle. When `expect_change` is set, the outputs must become `o`
    // exactly LAT cycles after the raw edge.
    task automatic press(input bit s, input bit c, input int hold,
                         input bit expect_change, input logic [2:0] o);
        int t0;
        @(posedge clk); #1;
        if (s) btn_start_stop = 1'b1;
        if (c) btn_clear = 1'b1;
        t0 = cyc;
        if (expect_change) push_exp(t0 + LAT, o);
        repeat (hold) @(posedge clk);
        #1;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        repeat (14) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        logic [5:0] bounce;

        // Reset: outputs must read IDLE while reset is held and afterwards.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("during_reset", O_IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_outs("idle_after_reset", O_IDLE);
        end
        mon_en = 1'b1;

        // Clean start press held 20 cycles -> RUNNING 8 cycles after the edge.
        press(1'b1, 1'b0, 20, 1'b1, O_RUNNING);

        // Bouncing start press: 1,0,1,1,0 then stable 1. One change to PAUSED,
        // 8 cycles after the final rising edge.
        bounce = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            btn_start_stop = bounce[i];
        end
        push_exp(cyc + LAT, O_PAUSED);
        repeat (15) @(posedge clk);
        #1 btn_start_stop = 1'b0;
        repeat (14) @(posedge clk);

        // 3-cycle glitches on either button fall short of the window.
        press(1'b1, 1'b0, 3, 1'b0, O_PAUSED);
        press(1'b0, 1'b1, 3, 1'b0, O_PAUSED);

        // Third start press -> RUNNING, fourth -> PAUSED again.
        press(1'b1, 1'b0, 10, 1'b1, O_RUNNING);
        press(1'b1, 1'b0, 30, 1'b1, O_PAUSED);

        // Start and clear on the same cycle from PAUSED: clear wins.
        press(1'b1, 1'b1, 10, 1'b1, O_IDLE);

        // Start -> RUNNING.
        press(1'b1, 1'b0, 10, 1'b1, O_RUNNING);

        // Start held, reset pulsed two cycles into the debounce count: IDLE on
        // the reset edge, then the still-held button is debounced afresh and
        // reaches RUNNING 8 cycles after reset release.
        @(posedge clk); #1;
        btn_start_stop = 1'b1;
        t0 = cyc;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        push_exp(t0 + 5, O_IDLE);
        push_exp(t0 + 5 + LAT, O_RUNNING);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1 btn_start_stop = 1'b0;
        repeat (14) @(posedge clk);

        // Clear from RUNNING -> IDLE; clear in IDLE changes nothing.
        press(1'b0, 1'b1, 12, 1'b1, O_IDLE);
        press(1'b0, 1'b1, 12, 1'b0, O_IDLE);

        @(negedge clk);
        check_outs("final_idle", O_IDLE);

        // Drain: any expectation still queued never showed up.
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        while (exp_q.size() > 0) begin
            logic [34:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_transition: outs never became %b at cycle %0d", e[2:0], int'(e[34:3]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

endmodule
